// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared FSM states and stream-format constants for the program loader.
package program_loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
    localparam int HDR_LEN = 2;
    localparam int CHK_W = 8;
    localparam int LEN_W = 8 * HDR_LEN;
endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: packs little-endian bytes into 32-bit words and flags the 4th byte.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic        word_done,
    output logic [31:0] word
);
    logic [1:0]  cnt;
    logic [23:0] sr;
    assign word_done = en && cnt == 2'd3;
    assign word = {din, sr};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sr <= '0;
        end else if (clr) begin
            cnt <= '0;
            sr <= '0;
        end else if (en) begin
            cnt <= cnt + 2'd1;
            sr <= {din, sr[23:8]};
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed, XOR-checked byte stream and writes it into instruction memory.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam logic [LEN_W-1:0] MAXW = LEN_W'(MAX_WORDS);
    state_t state, next;
    logic [LEN_W-1:0] len, widx, n;
    logic [CHK_W-1:0] chk;
    logic xfer, clr, en, word_done;
    logic [31:0] word;
    word_assembler u_asm (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .en(en),
        .din(rx_data),
        .word_done(word_done),
        .word(word)
    );
    always_comb begin
        next = state;
        clr = 1'b0;
        rx_ready = state inside {LEN_LO, LEN_HI, DATA, CHECK};
        xfer = rx_valid && rx_ready;
        en = xfer && state == DATA;
        n = {rx_data, len[7:0]};
        case (state)
            IDLE, DONE, ERROR: if (start) begin
                next = LEN_LO;
                clr = 1'b1;
            end
            LEN_LO: if (xfer) next = LEN_HI;
            LEN_HI: if (xfer) next = n == '0 ? CHECK : n > MAXW ? ERROR : DATA;
            DATA:   if (word_done && widx == len - LEN_W'(1)) next = CHECK;
            CHECK:  if (xfer) next = rx_data == chk ? DONE : ERROR;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end
    // Write strobe lands the cycle after the 4th byte, with address/data already latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
            widx <= '0;
            chk <= '0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wd <= '0;
        end else begin
            imem_we <= word_done;
            if (clr) begin
                len <= '0;
                widx <= '0;
                chk <= '0;
            end
            if (xfer && state == LEN_LO) len[7:0] <= rx_data;
            if (xfer && state == LEN_HI) len[15:8] <= rx_data;
            if (en) chk <= chk ^ rx_data;
            if (word_done) begin
                imem_wd <= word;
                imem_addr <= BASE_ADDR + {{(30-LEN_W){1'b0}}, widx, 2'b00};
                widx <= widx + LEN_W'(1);
            end
        end
    end
    assign cpu_hold = state != DONE;
    assign done = state == DONE;
    assign error = state == ERROR;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized scoreboard bench for program_loader against a stream-level reference model.
module tb_program_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int MAXW = 64;
    typedef logic [7:0] bq_t[$];
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_ready, imem_we, cpu_hold, done, error;
    logic [31:0] imem_addr, imem_wd;
    int checks = 0, failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wd(imem_wd),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wd);
            end else begin
                e = exp_q.pop_front();
                check("imem_write", {imem_addr, imem_wd}, e);
            end
        end
    end

    function automatic bq_t make_stream(input int n, input bit bad);
        bq_t s;
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n <= MAXW) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x ^= b;
                s.push_back(b);
            end
            s.push_back(bad ? x ^ 8'h01 : x);
        end
        return s;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic st);
        int t = 0;
        rx_data = b;
        rx_valid = 1'b1;
        start = st;
        @(negedge clk);
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Reference model: the whole stream decides the writes and the final outcome up front.
    task automatic run_session(input bq_t s, input int gap, input int restart_at);
        int n, nb, g;
        logic [7:0] x = 8'h00;
        logic [31:0] w;
        bit ok;
        n = int'({s[1], s[0]});
        if (n > MAXW) begin
            nb = 2;
            ok = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
                exp_q.push_back({BASE + 32'(4 * i), w});
                x ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            end
            nb = 2 + 4 * n + 1;
            ok = s[nb-1] == x;
        end
        pulse_start();
        for (int i = 0; i < nb; i++) begin
            g = gap == 1 ? int'(i > 0) : gap == 2 ? int'($urandom_range(0, 2)) : 0;
            if (g > 0) begin
                rx_valid = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
            send_byte(s[i], i == restart_at);
        end
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("done", 64'(done), 64'(ok));
        check("error", 64'(error), 64'(!ok));
        check("cpu_hold", 64'(cpu_hold), 64'(!ok));
        check("rx_ready_end", 64'(rx_ready), 64'd0);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t s, ref_s;
        int n;
        #3;
        check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_imem_wd", 64'(imem_wd), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Checksum byte is the XOR of the eight data bytes (0x2A).
        ref_s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        run_session(ref_s, 0, -1);
        run_session('{8'h00, 8'h00, 8'h00}, 0, -1);
        run_session('{8'h00, 8'h00, 8'h01}, 0, -1);
        run_session('{8'h41, 8'h00}, 0, -1);
        run_session(ref_s, 1, -1);
        run_session(ref_s, 0, 5);
        run_session(make_stream(MAXW, 1'b0), 2, -1);
        // Abort mid-load after 5 data bytes: only word 0 may have been written.
        exp_q.push_back({BASE, 32'h12345678});
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(ref_s[i], 1'b0);
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_cpu_hold", 64'(cpu_hold), 64'd1);
        check("abort_rx_ready", 64'(rx_ready), 64'd0);
        check("abort_imem_we", 64'(imem_we), 64'd0);
        check("abort_imem_addr", 64'(imem_addr), 64'd0);
        check("abort_imem_wd", 64'(imem_wd), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_error", 64'(error), 64'd0);
        check("abort_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_we", 64'(imem_we), 64'd0);
        end
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("idle_after_rst_ready", 64'(rx_ready), 64'd0);
        check("idle_after_rst_hold", 64'(cpu_hold), 64'd1);
        @(posedge clk);
        #1;
        run_session(ref_s, 0, -1);
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 9))
                6: n = 0;
                7: n = MAXW;
                8: n = MAXW + 1 + int'($urandom_range(0, 500));
                9: n = 2;
                default: n = int'($urandom_range(1, 6));
            endcase
            s = make_stream(n, $urandom_range(0, 3) == 0);
            run_session(s, int'($urandom_range(0, 2)), $urandom_range(0, 1) == 0 ? 4 : -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
